// File: rtl/cps2_video_pkg.sv
// CPS2 native video constants shared by the pattern generator and the scan
// converter: raster timing defaults, test-pattern selector and colour levels.
package cps2_video_pkg;

  // CPS2 raster timing, pixel clocks / lines
  localparam int CPS2_H_TOTAL     = 512;
  localparam int CPS2_H_SYNCLEN   = 31;
  localparam int CPS2_H_BACKPORCH = 66;
  localparam int CPS2_H_ACTIVE    = 384;
  localparam int CPS2_V_TOTAL     = 262;
  localparam int CPS2_V_SYNCLEN   = 3;
  localparam int CPS2_V_BACKPORCH = 16;
  localparam int CPS2_V_ACTIVE    = 224;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  localparam logic [3:0] COL_ON  = 4'hF;
  localparam logic [3:0] COL_OFF = 4'h0;

  // Expand a single on/off colour bit to a full 4-bit channel level.
  function automatic logic [3:0] rep4(input logic b);
    return b ? COL_ON : COL_OFF;
  endfunction

endpackage

// File: rtl/cps2_pattern_gen_if.sv
// Raw CPS2 video bus: 4-bit RGBF plus active-low syncs and a DE qualifier.
// The pattern generator drives it (master); the scan converter samples it.
interface cps2_pattern_gen_if;
  logic [3:0] R_out;
  logic [3:0] G_out;
  logic [3:0] B_out;
  logic [3:0] F_out;
  logic       HSYNC_out;
  logic       VSYNC_out;
  logic       DE_out;

  modport master (
    output R_out, G_out, B_out, F_out,
    output HSYNC_out, VSYNC_out, DE_out
  );

  modport slave (
    input R_out, G_out, B_out, F_out,
    input HSYNC_out, VSYNC_out, DE_out
  );
endinterface

// File: rtl/cps2_timing_counter.sv
// CPS2 raster counter: horizontal/vertical position, sync levels, active
// window, active-window pixel coordinates and a frame-start strobe.
// All outputs are combinational views of the current counter state; the
// parent registers them so every video output carries the same latency.
module cps2_timing_counter
  import cps2_video_pkg::*;
#(
  parameter int H_TOTAL     = CPS2_H_TOTAL,
  parameter int H_SYNCLEN   = CPS2_H_SYNCLEN,
  parameter int H_BACKPORCH = CPS2_H_BACKPORCH,
  parameter int H_ACTIVE    = CPS2_H_ACTIVE,
  parameter int V_TOTAL     = CPS2_V_TOTAL,
  parameter int V_SYNCLEN   = CPS2_V_SYNCLEN,
  parameter int V_BACKPORCH = CPS2_V_BACKPORCH,
  parameter int V_ACTIVE    = CPS2_V_ACTIVE
) (
  input  logic       PCLK_in,
  input  logic       reset,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_active,
  output logic       o_frame_start,
  output logic       o_first_px,
  output logic [8:0] o_x,
  output logic [7:0] o_y
);

  localparam logic [10:0] HT_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_LEN   = 11'(H_SYNCLEN);
  localparam logic [10:0] HA_START = 11'(H_SYNCLEN + H_BACKPORCH);
  localparam logic [10:0] HA_END   = 11'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
  localparam logic [9:0]  VT_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_LEN   = 10'(V_SYNCLEN);
  localparam logic [9:0]  VA_START = 10'(V_SYNCLEN + V_BACKPORCH);
  localparam logic [9:0]  VA_END   = 10'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);

  logic [10:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        w_h_act;
  logic        w_v_act;

  // Pixel counter wraps every line; line counter steps on each pixel wrap.
  always_ff @(posedge PCLK_in or posedge reset) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == HT_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == VT_LAST) ? '0 : r_vcnt + 10'd1;
    end else begin
      r_hcnt <= r_hcnt + 11'd1;
    end
  end

  // Decode sync, active window and coordinates from the current position.
  // vcnt only changes on the hcnt=0 cycle, so VSYNC edges land on HSYNC
  // falling edges without extra alignment logic.
  always_comb begin
    w_h_act       = (r_hcnt >= HA_START) && (r_hcnt < HA_END);
    w_v_act       = (r_vcnt >= VA_START) && (r_vcnt < VA_END);
    o_hsync_n     = !(r_hcnt < HS_LEN);
    o_vsync_n     = !(r_vcnt < VS_LEN);
    o_active      = w_h_act && w_v_act;
    o_frame_start = (r_hcnt == 11'd0) && (r_vcnt == 10'd0);
    o_first_px    = (r_hcnt == HA_START);
    o_x           = 9'(r_hcnt - HA_START);
    o_y           = 8'(r_vcnt - VA_START);
  end

endmodule

// File: rtl/cps2_pattern_gen.sv
// Board-less CPS2 video source. Produces CPS2-timed frames with one of four
// test patterns, in the raw RGBF/sync format the scan converter consumes.
// Every output is registered from the same counter state, so syncs, DE and
// pixel data stay mutually aligned.
module cps2_pattern_gen
  import cps2_video_pkg::*;
#(
  parameter int H_TOTAL     = CPS2_H_TOTAL,
  parameter int H_SYNCLEN   = CPS2_H_SYNCLEN,
  parameter int H_BACKPORCH = CPS2_H_BACKPORCH,
  parameter int H_ACTIVE    = CPS2_H_ACTIVE,
  parameter int V_TOTAL     = CPS2_V_TOTAL,
  parameter int V_SYNCLEN   = CPS2_V_SYNCLEN,
  parameter int V_BACKPORCH = CPS2_V_BACKPORCH,
  parameter int V_ACTIVE    = CPS2_V_ACTIVE
) (
  input  logic                PCLK_in,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          pattern_sel,
  cps2_pattern_gen_if.master  vid
);

  // Bar width in pixels minus one; eight equal bars across the active line.
  localparam logic [8:0] BAR_LAST = 9'(H_ACTIVE / 8 - 1);
  localparam logic [8:0] X_LAST   = 9'(H_ACTIVE - 1);
  localparam logic [7:0] Y_LAST   = 8'(V_ACTIVE - 1);

  logic       w_hsync_n;
  logic       w_vsync_n;
  logic       w_active;
  logic       w_frame_start;
  logic       w_first_px;
  logic [8:0] w_x;
  logic [7:0] w_y;

  pattern_e   r_pat;
  logic [7:0] r_frame_cnt;
  logic [2:0] r_bar_idx;
  logic [8:0] r_bar_sub;
  logic [2:0] w_bar_idx;
  logic [8:0] w_bar_sub;
  logic [8:0] w_chk_sum;
  logic       w_grid_hit;
  logic [3:0] w_r;
  logic [3:0] w_g;
  logic [3:0] w_b;
  logic [3:0] w_f;

  cps2_timing_counter #(
    .H_TOTAL     (H_TOTAL),
    .H_SYNCLEN   (H_SYNCLEN),
    .H_BACKPORCH (H_BACKPORCH),
    .H_ACTIVE    (H_ACTIVE),
    .V_TOTAL     (V_TOTAL),
    .V_SYNCLEN   (V_SYNCLEN),
    .V_BACKPORCH (V_BACKPORCH),
    .V_ACTIVE    (V_ACTIVE)
  ) u_timing (
    .PCLK_in       (PCLK_in),
    .reset         (reset),
    .o_hsync_n     (w_hsync_n),
    .o_vsync_n     (w_vsync_n),
    .o_active      (w_active),
    .o_frame_start (w_frame_start),
    .o_first_px    (w_first_px),
    .o_x           (w_x),
    .o_y           (w_y)
  );

  // Latch the pattern and step the frame counter only at frame start, so a
  // mid-frame pattern_sel change never tears the picture.
  always_ff @(posedge PCLK_in or posedge reset) begin
    if (reset) begin
      r_pat       <= PAT_BARS;
      r_frame_cnt <= '0;
    end else if (w_frame_start) begin
      r_pat       <= pattern_e'(pattern_sel);
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  // Bar state seen by the current pixel: forced to bar 0 at the first active
  // pixel so each line restarts cleanly whatever the previous line left.
  always_comb begin
    w_bar_idx = r_bar_idx;
    w_bar_sub = r_bar_sub;
    if (w_first_px) begin
      w_bar_idx = '0;
      w_bar_sub = '0;
    end
  end

  // Bar sub-counter: counts pixels within a bar and steps the bar index,
  // replacing an x / bar-width divide.
  always_ff @(posedge PCLK_in or posedge reset) begin
    if (reset) begin
      r_bar_idx <= '0;
      r_bar_sub <= '0;
    end else if (w_active) begin
      if (w_bar_sub == BAR_LAST) begin
        r_bar_sub <= '0;
        r_bar_idx <= w_bar_idx + 3'd1;
      end else begin
        r_bar_sub <= w_bar_sub + 9'd1;
        r_bar_idx <= w_bar_idx;
      end
    end
  end

  // Pixel colour for the current position; black outside the active window
  // or while disabled. The checker sum is 9 bits and wraps deliberately.
  always_comb begin
    w_r        = COL_OFF;
    w_g        = COL_OFF;
    w_b        = COL_OFF;
    w_f        = COL_OFF;
    w_chk_sum  = w_x + {1'b0, r_frame_cnt};
    w_grid_hit = (w_x[3:0] == 4'd0) || (w_y[3:0] == 4'd0) ||
                 (w_x == X_LAST) || (w_y == Y_LAST);
    if (w_active && enable) begin
      w_f = COL_ON;
      case (r_pat)
        PAT_BARS: begin
          w_r = rep4(~w_bar_idx[1]);
          w_g = rep4(~w_bar_idx[2]);
          w_b = rep4(~w_bar_idx[0]);
        end
        PAT_GRID: begin
          w_r = rep4(w_grid_hit);
          w_g = rep4(w_grid_hit);
          w_b = rep4(w_grid_hit);
        end
        PAT_GRAD: begin
          w_r = w_x[7:4];
          w_g = w_y[7:4];
          w_b = r_frame_cnt[7:4];
        end
        PAT_CHECK: begin
          w_r = rep4(w_chk_sum[4] ^ w_y[4]);
          w_g = rep4(w_chk_sum[4] ^ w_y[4]);
          w_b = rep4(w_chk_sum[4] ^ w_y[4]);
        end
        default: begin
          w_r = COL_OFF;
        end
      endcase
    end
  end

  // Output registers: everything reflects the counter state before the edge.
  always_ff @(posedge PCLK_in or posedge reset) begin
    if (reset) begin
      vid.HSYNC_out <= 1'b1;
      vid.VSYNC_out <= 1'b1;
      vid.DE_out    <= 1'b0;
      vid.R_out     <= COL_OFF;
      vid.G_out     <= COL_OFF;
      vid.B_out     <= COL_OFF;
      vid.F_out     <= COL_OFF;
    end else begin
      vid.HSYNC_out <= w_hsync_n;
      vid.VSYNC_out <= w_vsync_n;
      vid.DE_out    <= w_active;
      vid.R_out     <= w_r;
      vid.G_out     <= w_g;
      vid.B_out     <= w_b;
      vid.F_out     <= w_f;
    end
  end

endmodule

// File: tb/tb_cps2_pattern_gen.sv
// Directed bench for cps2_pattern_gen. A default-timing instance checks the
// real CPS2 line/sync/DE timing; a shrunken-raster instance (64x24 total,
// 48x18 active) makes multi-frame pattern, enable and frame-counter cases
// affordable. Bench position (b_h, b_v, b_frame) tracks the shrunken raster.
module tb_cps2_pattern_gen;

  localparam int SHT = 64, SHS = 4, SHB = 6, SHA = 48;
  localparam int SVT = 24, SVS = 2, SVB = 3, SVA = 18;
  localparam int SH0 = SHS + SHB;
  localparam int SV0 = SVS + SVB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [1:0] sel = 2'd0;

  int vectors     = 0;
  int miscompares = 0;
  int b_h = 0, b_v = 0, b_frame = 0, g_ticks = 0;
  bit b_fresh = 1'b0;

  // bar colours white, yellow, cyan, green, magenta, red, blue, black
  logic [3:0] exp_r [8] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
  logic [3:0] exp_g [8] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] exp_b [8] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};

  always #5 clk = ~clk;

  cps2_pattern_gen_if sif ();
  cps2_pattern_gen_if dif ();

  cps2_pattern_gen #(
    .H_TOTAL(SHT), .H_SYNCLEN(SHS), .H_BACKPORCH(SHB), .H_ACTIVE(SHA),
    .V_TOTAL(SVT), .V_SYNCLEN(SVS), .V_BACKPORCH(SVB), .V_ACTIVE(SVA)
  ) u_small (
    .PCLK_in(clk), .reset(rst), .enable(en), .pattern_sel(sel), .vid(sif)
  );

  cps2_pattern_gen u_dflt (
    .PCLK_in(clk), .reset(rst), .enable(en), .pattern_sel(sel), .vid(dif)
  );

  function automatic logic [3:0] exp_chk(input int x, input int y, input int fc);
    int s;
    s = (x + fc) % 512;
    return ((((s >> 4) & 1) ^ ((y >> 4) & 1)) != 0) ? 4'hF : 4'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (b_fresh) begin
      b_h = 0; b_v = 0; b_frame = 0; g_ticks = 1; b_fresh = 1'b0;
    end else begin
      g_ticks++;
      if (b_h == SHT - 1) begin
        b_h = 0;
        if (b_v == SVT - 1) begin b_v = 0; b_frame++; end
        else b_v++;
      end else begin
        b_h++;
      end
    end
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    do begin tick(); n++; end
    while (!(b_h == h && b_v == v) && n < 2 * SHT * SVT + 4);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({sif.HSYNC_out, sif.VSYNC_out, sif.DE_out} !== 3'b110) begin
      miscompares++;
      $display("FAIL reset_sync_small: got %b want 110", {sif.HSYNC_out, sif.VSYNC_out, sif.DE_out});
    end
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_rgbf_small: got %h want 0000", {sif.R_out, sif.G_out, sif.B_out, sif.F_out});
    end
    vectors++;
    if ({dif.HSYNC_out, dif.VSYNC_out, dif.DE_out, dif.F_out} !== 7'b110_0000) begin
      miscompares++;
      $display("FAIL reset_dflt: got %b want 1100000", {dif.HSYNC_out, dif.VSYNC_out, dif.DE_out, dif.F_out});
    end
    @(negedge clk);
    rst = 1'b0;
    b_fresh = 1'b1;
  endtask

  // Runs from reset release: HSYNC 31/512, VSYNC 1536, first DE at line 19
  // pixel 97, 384-pixel colour-bar line.
  task automatic test_default_timing();
    int n;
    tick();
    vectors++;
    if (sif.HSYNC_out !== 1'b0) begin
      miscompares++;
      $display("FAIL first_hsync_small: got %b want 0", sif.HSYNC_out);
    end
    vectors++;
    if (dif.HSYNC_out !== 1'b0) begin
      miscompares++;
      $display("FAIL first_hsync_dflt: got %b want 0", dif.HSYNC_out);
    end
    n = 1;
    tick();
    while (dif.HSYNC_out === 1'b0 && n < 1000) begin n++; tick(); end
    vectors++;
    if (n != 31) begin
      miscompares++;
      $display("FAIL hsync_width: got %0d want 31", n);
    end
    while (dif.HSYNC_out === 1'b1 && n < 1200) begin n++; tick(); end
    vectors++;
    if (n != 512) begin
      miscompares++;
      $display("FAIL hsync_period: got %0d want 512", n);
    end
    while (dif.VSYNC_out === 1'b0 && g_ticks < 3000) tick();
    vectors++;
    if (g_ticks - 1 != 1536) begin
      miscompares++;
      $display("FAIL vsync_width: got %0d want 1536", g_ticks - 1);
    end
    while (dif.DE_out !== 1'b1 && g_ticks < 12000) tick();
    vectors++;
    if (g_ticks - 1 != 19 * 512 + 97) begin
      miscompares++;
      $display("FAIL first_de_pos: got %0d want %0d", g_ticks - 1, 19 * 512 + 97);
    end
    n = 0;
    while (dif.DE_out === 1'b1 && n < 400) begin
      if (n < 384) begin
        vectors++;
        if ({dif.R_out, dif.G_out, dif.B_out, dif.F_out} !==
            {exp_r[n / 48], exp_g[n / 48], exp_b[n / 48], 4'hF}) begin
          miscompares++;
          $display("FAIL dflt_bar_px%0d: got %h want %h", n,
                   {dif.R_out, dif.G_out, dif.B_out, dif.F_out},
                   {exp_r[n / 48], exp_g[n / 48], exp_b[n / 48], 4'hF});
        end
      end
      n++;
      tick();
    end
    vectors++;
    if (n != 384) begin
      miscompares++;
      $display("FAIL de_width: got %0d want 384", n);
    end
    vectors++;
    if ({dif.R_out, dif.G_out, dif.B_out, dif.F_out} !== 16'h0000) begin
      miscompares++;
      $display("FAIL after_de_rgbf: got %h want 0000", {dif.R_out, dif.G_out, dif.B_out, dif.F_out});
    end
  endtask

  task automatic test_bars();
    goto(SH0 - 1, SV0);
    vectors++;
    if ({sif.DE_out, sif.F_out} !== 5'b0_0000) begin
      miscompares++;
      $display("FAIL bars_pre_de: got %b want 00000", {sif.DE_out, sif.F_out});
    end
    for (int x = 0; x < SHA; x++) begin
      tick();
      vectors++;
      if ({sif.DE_out, sif.R_out, sif.G_out, sif.B_out, sif.F_out} !==
          {1'b1, exp_r[x / 6], exp_g[x / 6], exp_b[x / 6], 4'hF}) begin
        miscompares++;
        $display("FAIL bars_x%0d: got %h want %h", x,
                 {sif.DE_out, sif.R_out, sif.G_out, sif.B_out, sif.F_out},
                 {1'b1, exp_r[x / 6], exp_g[x / 6], exp_b[x / 6], 4'hF});
      end
    end
    tick();
    vectors++;
    if ({sif.DE_out, sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== 17'h0) begin
      miscompares++;
      $display("FAIL bars_post_de: got %h want 0", {sif.DE_out, sif.R_out, sif.G_out, sif.B_out, sif.F_out});
    end
  endtask

  task automatic test_grid();
    int         gh [6] = '{10, 11, 15, 57, 27, 15};
    int         gv [6] = '{5, 6, 10, 10, 20, 22};
    logic [11:0] ge [6] = '{12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
    sel = 2'd1;
    goto(0, 0);
    for (int i = 0; i < 6; i++) begin
      goto(gh[i], gv[i]);
      vectors++;
      if ({sif.R_out, sif.G_out, sif.B_out} !== ge[i]) begin
        miscompares++;
        $display("FAIL grid_x%0d_y%0d: got %h want %h", gh[i] - SH0, gv[i] - SV0,
                 {sif.R_out, sif.G_out, sif.B_out}, ge[i]);
      end
    end
  endtask

  task automatic test_gradient();
    logic [7:0] fc;
    sel = 2'd2;
    goto(0, 0);
    fc = 8'(b_frame + 1);
    goto(SH0 + 20, SV0 + 2);
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== {4'h1, 4'h0, fc[7:4], 4'hF}) begin
      miscompares++;
      $display("FAIL grad_20_2: got %h want %h", {sif.R_out, sif.G_out, sif.B_out, sif.F_out},
               {4'h1, 4'h0, fc[7:4], 4'hF});
    end
    goto(SH0 + 33, SV0 + 17);
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== {4'h2, 4'h1, fc[7:4], 4'hF}) begin
      miscompares++;
      $display("FAIL grad_33_17: got %h want %h", {sif.R_out, sif.G_out, sif.B_out, sif.F_out},
               {4'h2, 4'h1, fc[7:4], 4'hF});
    end
  endtask

  task automatic test_pattern_switch();
    logic [3:0] e;
    sel = 2'd0;
    goto(0, 0);
    goto(0, 10);
    sel = 2'd3;
    goto(SH0, 10);
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL switch_bars_x0: got %h want FFFF", {sif.R_out, sif.G_out, sif.B_out, sif.F_out});
    end
    goto(SH0 + 6, 10);
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== 16'hFF0F) begin
      miscompares++;
      $display("FAIL switch_bars_x6: got %h want FF0F", {sif.R_out, sif.G_out, sif.B_out, sif.F_out});
    end
    goto(0, 0);
    e = exp_chk(0, 0, (b_frame + 1) % 256);
    goto(SH0, SV0);
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== {e, e, e, 4'hF}) begin
      miscompares++;
      $display("FAIL switch_chk_00: got %h want %h", {sif.R_out, sif.G_out, sif.B_out, sif.F_out}, {e, e, e, 4'hF});
    end
    while (b_frame < 14) goto(0, 0);
    // frame_cnt = 15 in this frame
    goto(SH0, SV0);
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out} !== 12'h000) begin
      miscompares++;
      $display("FAIL chk_fc15_x0: got %h want 000", {sif.R_out, sif.G_out, sif.B_out});
    end
    goto(SH0 + 16, SV0);
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out} !== 12'hFFF) begin
      miscompares++;
      $display("FAIL chk_fc15_x16: got %h want FFF", {sif.R_out, sif.G_out, sif.B_out});
    end
    goto(0, 0);
    // frame_cnt = 16 in this frame
    goto(SH0, SV0);
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out} !== 12'hFFF) begin
      miscompares++;
      $display("FAIL chk_fc16_x0: got %h want FFF", {sif.R_out, sif.G_out, sif.B_out});
    end
    goto(SH0, SV0 + 16);
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out} !== 12'h000) begin
      miscompares++;
      $display("FAIL chk_fc16_y16: got %h want 000", {sif.R_out, sif.G_out, sif.B_out});
    end
  endtask

  task automatic test_enable();
    int nz, de, hs, vs, bad_de;
    bit exp_de;
    nz = 0; de = 0; hs = 0; vs = 0; bad_de = 0;
    sel = 2'd0;
    en  = 1'b0;
    goto(0, 0);
    for (int i = 0; i < SHT * SVT; i++) begin
      if (i > 0) tick();
      exp_de = (b_h >= SH0) && (b_h < SH0 + SHA) && (b_v >= SV0) && (b_v < SV0 + SVA);
      if ({sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== 16'h0000) nz++;
      if (sif.DE_out === 1'b1) de++;
      if (sif.DE_out !== exp_de) bad_de++;
      if (sif.HSYNC_out === 1'b0) hs++;
      if (sif.VSYNC_out === 1'b0) vs++;
    end
    vectors++;
    if (nz != 0) begin miscompares++; $display("FAIL dis_rgbf_nonzero: got %0d want 0", nz); end
    vectors++;
    if (de != SHA * SVA) begin miscompares++; $display("FAIL dis_de_count: got %0d want %0d", de, SHA * SVA); end
    vectors++;
    if (bad_de != 0) begin miscompares++; $display("FAIL dis_de_position: got %0d want 0", bad_de); end
    vectors++;
    if (hs != SHS * SVT) begin miscompares++; $display("FAIL dis_hsync_count: got %0d want %0d", hs, SHS * SVT); end
    vectors++;
    if (vs != SVS * SHT) begin miscompares++; $display("FAIL dis_vsync_count: got %0d want %0d", vs, SVS * SHT); end
    goto(SH0 + 9, 8);
    vectors++;
    if ({sif.DE_out, sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== 17'h10000) begin
      miscompares++;
      $display("FAIL dis_midline: got %h want 10000", {sif.DE_out, sif.R_out, sif.G_out, sif.B_out, sif.F_out});
    end
    en = 1'b1;
    tick();
    vectors++;
    if ({sif.R_out, sif.G_out, sif.B_out, sif.F_out} !== 16'hFF0F) begin
      miscompares++;
      $display("FAIL reenable_next: got %h want FF0F", {sif.R_out, sif.G_out, sif.B_out, sif.F_out});
    end
  endtask

  task automatic test_reset_midline();
    int n;
    n = 0;
    while (g_ticks - 1 != 100 * 512 + 200 && n < 60000) begin tick(); n++; end
    vectors++;
    if ({dif.DE_out, dif.F_out} !== 5'b1_1111) begin
      miscompares++;
      $display("FAIL pre_reset_active: got %b want 11111", {dif.DE_out, dif.F_out});
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({dif.HSYNC_out, dif.VSYNC_out, dif.DE_out, dif.R_out, dif.G_out, dif.B_out, dif.F_out} !==
        {3'b110, 16'h0000}) begin
      miscompares++;
      $display("FAIL async_reset_dflt: got %h want %h",
               {dif.HSYNC_out, dif.VSYNC_out, dif.DE_out, dif.R_out, dif.G_out, dif.B_out, dif.F_out},
               {3'b110, 16'h0000});
    end
    vectors++;
    if ({sif.HSYNC_out, sif.VSYNC_out, sif.DE_out, sif.F_out} !== 7'b110_0000) begin
      miscompares++;
      $display("FAIL async_reset_small: got %b want 1100000",
               {sif.HSYNC_out, sif.VSYNC_out, sif.DE_out, sif.F_out});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b_fresh = 1'b1;
    test_default_timing();
  endtask

  initial begin
    test_reset();
    test_default_timing();
    test_bars();
    test_grid();
    test_gradient();
    test_pattern_switch();
    test_enable();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
